// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// The optional SIGNED_MODE_EN macro is consumed by the datapath, not here.
package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } mult_state_t;

  // Step counter must be able to hold values 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Operand/accumulator datapath for seq_mult_unit, driven by load/step/finish strobes.
// Define SIGNED_MODE_EN for two's-complement operands (magnitude multiply plus sign fix-up).
module seq_mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 finish_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 zero_op_o,
  output logic                 last_step_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int CW = cnt_width(WIDTH);

  logic [2*WIDTH-1:0] areg_q, areg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   breg_q, breg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] result;

  assign zero_op_o = (a_i == '0) || (b_i == '0);

`ifdef SIGNED_MODE_EN
  logic neg_q, neg_d;

  // Most-negative input negates to 2^(WIDTH-1), which still fits unsigned.
  assign a_mag  = a_i[WIDTH-1] ? -a_i : a_i;
  assign b_mag  = b_i[WIDTH-1] ? -b_i : b_i;
  assign neg_d  = load_i ? ((a_i[WIDTH-1] ^ b_i[WIDTH-1]) && !zero_op_o) : neg_q;
  assign result = neg_q ? -acc_q : acc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) neg_q <= 1'b0;
    else       neg_q <= neg_d;
  end
`else
  assign a_mag  = a_i;
  assign b_mag  = b_i;
  assign result = acc_q;
`endif

  assign last_step_o = ((breg_q >> 1) == '0) || (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    areg_d    = areg_q;
    breg_d    = breg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (load_i) begin
      areg_d = {{WIDTH{1'b0}}, a_mag};
      breg_d = b_mag;
      acc_d  = '0;
      cnt_d  = '0;
    end else if (step_i) begin
      if (breg_q[0]) acc_d = acc_q + areg_q;
      areg_d = areg_q << 1;
      breg_d = breg_q >> 1;
      cnt_d  = cnt_q + CW'(1);
    end
    if (finish_i) product_d = result;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      areg_q    <= '0;
      breg_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      areg_q    <= areg_d;
      breg_q    <= breg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= finish_i;
    end
  end

  assign done_o    = done_q;
  assign product_o = product_q;

endmodule

// File: rtl/seq_mult_unit.sv
// Sequential shift-add multiplier: GO/START handshake controller around seq_mult_datapath.
// Define SIGNED_MODE_EN to treat A and B as two's complement.
module seq_mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               SYS_CLOCK,
  input  logic               FSM_SRESET,
  input  logic               GO,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               START,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] PRODUCT,
  output logic [1:0]         DBG_STATE
);

  // Handshake: a request is taken on any posedge where START=1 and GO=1;
  // GO while START=0 is dropped, and DONE pulses once with PRODUCT valid.
  mult_state_t state_q, state_d;
  logic        load, step, finish;
  logic        zero_op, last_step;

  assign START     = (state_q == S_IDLE);
  assign BUSY      = (state_q == S_CALC) || (state_q == S_DONE);
  assign load      = START && GO;
  assign step      = (state_q == S_CALC);
  assign finish    = (state_q == S_DONE);
  assign DBG_STATE = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (GO) state_d = zero_op ? S_DONE : S_CALC;
      S_CALC:  if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLOCK) begin
    if (FSM_SRESET) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  seq_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk_i       (SYS_CLOCK),
    .rst_i       (FSM_SRESET),
    .load_i      (load),
    .step_i      (step),
    .finish_i    (finish),
    .a_i         (A),
    .b_i         (B),
    .zero_op_o   (zero_op),
    .last_step_o (last_step),
    .done_o      (DONE),
    .product_o   (PRODUCT)
  );

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed bench for seq_mult_unit (WIDTH=8); signed vectors run when SIGNED_MODE_EN is defined.
module tb_seq_mult_unit;

  localparam int W = 8;

  logic           SYS_CLOCK;
  logic           FSM_SRESET;
  logic           GO;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           START;
  logic           BUSY;
  logic           DONE;
  logic [2*W-1:0] PRODUCT;
  logic [1:0]     DBG_STATE;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] exp_q[$];

  seq_mult_unit #(.WIDTH(W)) dut (
    .SYS_CLOCK  (SYS_CLOCK),
    .FSM_SRESET (FSM_SRESET),
    .GO         (GO),
    .A          (A),
    .B          (B),
    .START      (START),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .PRODUCT    (PRODUCT),
    .DBG_STATE  (DBG_STATE)
  );

  // Clock
  initial begin
    SYS_CLOCK = 1'b0;
    forever #5 SYS_CLOCK = ~SYS_CLOCK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    FSM_SRESET = 1'b1;
    repeat (2) @(posedge SYS_CLOCK);
    #1 FSM_SRESET = 1'b0;
  endtask

  // Present an operation before edge 0; returns just after edge 0.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp, input bit hold_go);
    @(negedge SYS_CLOCK);
    A  = a;
    B  = b;
    GO = 1'b1;
    exp_q.push_back(exp);
    @(posedge SYS_CLOCK);
    #1;
    if (!hold_go) GO = 1'b0;
  endtask

  // Counts edges after edge 0 until DONE, bounded, then scores the result.
  task automatic finish_op(input string tag, input int exp_edges, input bit check_hold);
    int edges;
    logic [2*W-1:0] exp;
    edges = 0;
    do begin
      @(posedge SYS_CLOCK);
      #1;
      edges++;
    end while (DONE !== 1'b1 && edges < 40);
    check({tag, "_done"}, {31'b0, DONE}, 32'd1);
    check({tag, "_latency"}, edges, exp_edges);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_product"}, {16'b0, PRODUCT}, {16'b0, exp});
    check({tag, "_start"}, {31'b0, START}, 32'd1);
    if (check_hold) begin
      @(posedge SYS_CLOCK);
      #1;
      check({tag, "_done_pulse"}, {31'b0, DONE}, 32'd0);
      check({tag, "_hold"}, {16'b0, PRODUCT}, {16'b0, exp});
    end
  endtask

  initial begin
    GO = 1'b0;
    A  = '0;
    B  = '0;
    apply_reset();

    check("rst_start", {31'b0, START}, 32'd1);
    check("rst_busy", {31'b0, BUSY}, 32'd0);
    check("rst_done", {31'b0, DONE}, 32'd0);
    check("rst_product", {16'b0, PRODUCT}, 32'd0);
    check("rst_state", {30'b0, DBG_STATE}, 32'd0);

`ifdef SIGNED_MODE_EN
    issue(8'h80, 8'hFF, 16'd128, 1'b0);
    finish_op("s_m128_m1", 2, 1'b1);
    issue(8'hFD, 8'd5, 16'hFFF1, 1'b0);
    finish_op("s_m3_5", 4, 1'b1);
    issue(8'd0, 8'hFB, 16'd0, 1'b0);
    finish_op("s_zero", 1, 1'b1);
    issue(8'd7, 8'hFE, 16'hFFF2, 1'b0);
    finish_op("s_7_m2", 3, 1'b1);
`else
    issue(8'd3, 8'd5, 16'd15, 1'b0);
    check("u_3_5_busy", {31'b0, BUSY}, 32'd1);
    finish_op("u_3_5", 4, 1'b1);

    issue(8'd0, 8'd200, 16'd0, 1'b0);
    check("u_zero_state", {30'b0, DBG_STATE}, 32'd2);
    finish_op("u_zero", 1, 1'b1);

    issue(8'd255, 8'd255, 16'd65025, 1'b0);
    finish_op("u_255_255", 9, 1'b1);

    issue(8'd200, 8'd128, 16'd25600, 1'b0);
    finish_op("u_200_128", 9, 1'b1);

    // GO held through the operation with junk operands; re-issue on the DONE cycle.
    issue(8'd10, 8'd3, 16'd30, 1'b1);
    A = 8'd99;
    B = 8'd99;
    finish_op("u_held", 3, 1'b0);
    A = 8'd7;
    B = 8'd2;
    exp_q.push_back(16'd14);
    @(posedge SYS_CLOCK);
    #1;
    GO = 1'b0;
    check("u_b2b_accept", {31'b0, START}, 32'd0);
    finish_op("u_b2b", 3, 1'b1);
`endif

    // Reset while in S_CALC aborts the operation.
    @(negedge SYS_CLOCK);
    A  = 8'd127;
    B  = 8'd127;
    GO = 1'b1;
    @(posedge SYS_CLOCK);
    #1 GO = 1'b0;
    @(posedge SYS_CLOCK);
    #1;
    check("abort_in_calc", {30'b0, DBG_STATE}, 32'd1);
    FSM_SRESET = 1'b1;
    @(posedge SYS_CLOCK);
    #1 FSM_SRESET = 1'b0;
    check("abort_start", {31'b0, START}, 32'd1);
    check("abort_done", {31'b0, DONE}, 32'd0);
    check("abort_product", {16'b0, PRODUCT}, 32'd0);
    repeat (10) @(posedge SYS_CLOCK);
    #1;
    check("abort_no_done", {31'b0, DONE}, 32'd0);
    check("abort_idle", {31'b0, BUSY}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
